pe_dispatch_scheduler: RTL and testbench

Credit-based round-robin scheduler that feeds one input operand stream to four processing elements (PEs) through the 1:4 demux path in the PE computation array. Each accepted word goes to exactly one lane, chosen round-robin among lanes with a free credit. A lane's credit returns when that PE pulses `done`. The `sel` output drives the demux select lines `{s1, s0}`, and `out_valid` is the per-lane one-hot strobe.

---
 rtl/pe_dispatch_scheduler.sv | 116 +++++++++++
 tb/tb_pe_dispatch_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pe_dispatch_scheduler.sv
// pe_dispatch_scheduler
// Credit-based round-robin dispatcher: one operand stream fanned out to four
// PE lanes through a 1:4 demux. A one-entry holding register decouples the
// upstream handshake from lane availability. Each lane holds up to CREDITS
// outstanding jobs; a done pulse on a lane returns one credit to it.
module pe_dispatch_scheduler #(
    parameter int WIDTH   = 8,
    parameter int CREDITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       done,
    output logic [3:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic [3:0]       busy,
    output logic             credit_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic [1:0]       ptr;
    logic [CW-1:0]    credit [4];

    logic             grant_found;
    logic [1:0]       grant;
    logic [1:0]       idx;
    logic             dispatch;
    logic [3:0]       take;
    logic [3:0]       ovf;

    // Credit update: a return and a same-cycle take cancel; a return into a
    // full counter saturates at the maximum (the overflow is flagged elsewhere).
    function automatic logic [CW-1:0] next_credit(input logic [CW-1:0] c,
                                                   input logic inc,
                                                   input logic dec);
        logic [CW-1:0] r;
        r = c;
        if (inc && !dec) begin
            if (c != CMAX) r = c + 1'b1;
        end else if (dec && !inc) begin
            r = c - 1'b1;
        end
        return r;
    endfunction

    // Round-robin scan starting at ptr: first lane holding a credit wins.
    always_comb begin
        grant_found = 1'b0;
        grant       = ptr;
        idx         = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!grant_found && credit[idx] != '0) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
    end

    assign dispatch = hold_valid && grant_found;
    assign in_ready = !hold_valid || dispatch;

    // Per-lane decode: which lane is taken this cycle, empty lanes, overflow.
    always_comb begin
        take = '0;
        busy = '0;
        ovf  = '0;
        for (int i = 0; i < 4; i++) begin
            take[i] = dispatch && (grant == 2'(i));
            busy[i] = (credit[i] == '0);
            ovf[i]  = done[i] && !take[i] && (credit[i] == CMAX);
        end
    end

    // Holding register, dispatch outputs, pointer, credits and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            out_valid  <= '0;
            out_data   <= '0;
            sel        <= '0;
            ptr        <= '0;
            credit_err <= 1'b0;
            for (int i = 0; i < 4; i++) credit[i] <= CMAX;
        end else begin
            if (in_valid && in_ready) begin
                hold_valid <= 1'b1;
                hold_data  <= in_data;
            end else if (dispatch) begin
                hold_valid <= 1'b0;
            end

            out_valid <= dispatch ? (4'b0001 << grant) : 4'b0000;
            if (dispatch) begin
                out_data <= hold_data;
                sel      <= grant;
                ptr      <= grant + 2'd1;
            end

            for (int i = 0; i < 4; i++) begin
                credit[i] <= next_credit(credit[i], done[i], take[i]);
            end

            if (|ovf) credit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_dispatch_scheduler.sv
// Directed, table-driven bench for pe_dispatch_scheduler (WIDTH=8, CREDITS=2).
// Each table row drives one cycle of inputs, optionally checks the
// combinational in_ready before the edge, then checks the registered outputs
// and busy/credit_err just after the edge.
module tb_pe_dispatch_scheduler;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] done;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [1:0] sel;
    logic [3:0] busy;
    logic       credit_err;

    int checks = 0;
    int errors = 0;
    int row    = 0;

    pe_dispatch_scheduler #(.WIDTH(8), .CREDITS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .done       (done),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .sel        (sel),
        .busy       (busy),
        .credit_err (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] id;
        logic [3:0] dn;
        logic       chk_rdy;
        logic       rdy;
        logic [3:0] ov;
        logic [1:0] sel;
        logic [7:0] od;
        logic [3:0] busy;
        logic       err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic iv, input logic [7:0] id,
                       input logic [3:0] dn, input logic chk_rdy, input logic rdy,
                       input logic [3:0] ov, input logic [1:0] s, input logic [7:0] od,
                       input logic [3:0] b, input logic err);
        vec_t v;
        v.rst = rst; v.iv = iv; v.id = id; v.dn = dn;
        v.chk_rdy = chk_rdy; v.rdy = rdy;
        v.ov = ov; v.sel = s; v.od = od; v.busy = b; v.err = err;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
        end
    endtask

    initial begin
        bit seen;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        done     = '0;

        //   rst iv id     dn    crdy rdy  ov    sel od     busy  err
        // reset, with done pulses that must be ignored
        add(1, 0, 8'h00, 4'h0, 0, 0, 4'h0, 0, 8'h00, 4'h0, 0);
        add(1, 0, 8'h00, 4'hF, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0);
        // round-robin streaming 0x11..0x18, then a 9th word held
        add(0, 1, 8'h11, 4'h0, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0);
        add(0, 1, 8'h12, 4'h0, 1, 1, 4'h1, 0, 8'h11, 4'h0, 0);
        add(0, 1, 8'h13, 4'h0, 1, 1, 4'h2, 1, 8'h12, 4'h0, 0);
        add(0, 1, 8'h14, 4'h0, 1, 1, 4'h4, 2, 8'h13, 4'h0, 0);
        add(0, 1, 8'h15, 4'h0, 1, 1, 4'h8, 3, 8'h14, 4'h0, 0);
        add(0, 1, 8'h16, 4'h0, 1, 1, 4'h1, 0, 8'h15, 4'h1, 0);
        add(0, 1, 8'h17, 4'h0, 1, 1, 4'h2, 1, 8'h16, 4'h3, 0);
        add(0, 1, 8'h18, 4'h0, 1, 1, 4'h4, 2, 8'h17, 4'h7, 0);
        add(0, 1, 8'h19, 4'h0, 1, 1, 4'h8, 3, 8'h18, 4'hF, 0);
        add(0, 1, 8'h1A, 4'h0, 1, 0, 4'h0, 3, 8'h18, 4'hF, 0);
        add(0, 0, 8'h00, 4'h0, 1, 0, 4'h0, 3, 8'h18, 4'hF, 0);
        // credit return on lane 2 unblocks the held 0x19
        add(0, 0, 8'h00, 4'h4, 1, 0, 4'h0, 3, 8'h18, 4'hB, 0);
        add(0, 0, 8'h00, 4'h0, 1, 1, 4'h4, 2, 8'h19, 4'hF, 0);
        // set up ptr=1 with lanes 1,2 empty and lanes 0,3 full
        add(0, 0, 8'h00, 4'h9, 1, 1, 4'h0, 2, 8'h19, 4'h6, 0);
        add(0, 1, 8'h30, 4'h0, 1, 1, 4'h0, 2, 8'h19, 4'h6, 0);
        add(0, 1, 8'h31, 4'h0, 1, 1, 4'h8, 3, 8'h30, 4'hE, 0);
        add(0, 0, 8'h00, 4'h0, 1, 1, 4'h1, 0, 8'h31, 4'hF, 0);
        add(0, 0, 8'h00, 4'h9, 1, 1, 4'h0, 0, 8'h31, 4'h6, 0);
        add(0, 0, 8'h00, 4'h9, 1, 1, 4'h0, 0, 8'h31, 4'h6, 0);
        // skip busy lanes: grants 3,0,3
        add(0, 1, 8'hA0, 4'h0, 1, 1, 4'h0, 0, 8'h31, 4'h6, 0);
        add(0, 1, 8'hA1, 4'h0, 1, 1, 4'h8, 3, 8'hA0, 4'h6, 0);
        add(0, 1, 8'hA2, 4'h0, 1, 1, 4'h1, 0, 8'hA1, 4'h6, 0);
        add(0, 0, 8'h00, 4'h0, 1, 1, 4'h8, 3, 8'hA2, 4'hE, 0);
        // simultaneous done[0] and dispatch to lane 0 with credit[0]=1
        add(0, 1, 8'h40, 4'h0, 1, 1, 4'h0, 3, 8'hA2, 4'hE, 0);
        add(0, 0, 8'h00, 4'h1, 1, 1, 4'h1, 0, 8'h40, 4'hE, 0);
        // refill lane 3, then one extra done -> sticky credit_err
        add(0, 0, 8'h00, 4'h8, 1, 1, 4'h0, 0, 8'h40, 4'h6, 0);
        add(0, 0, 8'h00, 4'h8, 1, 1, 4'h0, 0, 8'h40, 4'h6, 0);
        add(0, 0, 8'h00, 4'h8, 1, 1, 4'h0, 0, 8'h40, 4'h6, 1);
        add(0, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 8'h40, 4'h6, 1);
        // reset while a word is held and credits are partly used
        add(0, 1, 8'h55, 4'h0, 1, 1, 4'h0, 0, 8'h40, 4'h6, 1);
        add(1, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0);
        add(0, 0, 8'h00, 4'h0, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0);
        // full credits restored: eight dispatches before all lanes go busy
        add(0, 1, 8'h61, 4'h0, 1, 1, 4'h0, 0, 8'h00, 4'h0, 0);
        add(0, 1, 8'h62, 4'h0, 1, 1, 4'h1, 0, 8'h61, 4'h0, 0);
        add(0, 1, 8'h63, 4'h0, 1, 1, 4'h2, 1, 8'h62, 4'h0, 0);
        add(0, 1, 8'h64, 4'h0, 1, 1, 4'h4, 2, 8'h63, 4'h0, 0);
        add(0, 1, 8'h65, 4'h0, 1, 1, 4'h8, 3, 8'h64, 4'h0, 0);
        add(0, 1, 8'h66, 4'h0, 1, 1, 4'h1, 0, 8'h65, 4'h1, 0);
        add(0, 1, 8'h67, 4'h0, 1, 1, 4'h2, 1, 8'h66, 4'h3, 0);
        add(0, 1, 8'h68, 4'h0, 1, 1, 4'h4, 2, 8'h67, 4'h7, 0);
        add(0, 0, 8'h00, 4'h0, 1, 1, 4'h8, 3, 8'h68, 4'hF, 0);
        add(0, 0, 8'h00, 4'h0, 1, 1, 4'h0, 3, 8'h68, 4'hF, 0);

        for (int r = 0; r < vq.size(); r++) begin
            row = r;
            @(negedge clk);
            reset    = vq[r].rst;
            in_valid = vq[r].iv;
            in_data  = vq[r].id;
            done     = vq[r].dn;
            #1;
            if (vq[r].chk_rdy) chk("in_ready", 32'(in_ready), 32'(vq[r].rdy));
            @(posedge clk);
            #1;
            chk("out_valid",  32'(out_valid),  32'(vq[r].ov));
            chk("sel",        32'(sel),        32'(vq[r].sel));
            chk("out_data",   32'(out_data),   32'(vq[r].od));
            chk("busy",       32'(busy),       32'(vq[r].busy));
            chk("credit_err", 32'(credit_err), 32'(vq[r].err));
        end

        // All lanes empty: hold 0x70, confirm in_ready ignores in_valid, then
        // free lane 1 and wait (bounded) for the dispatch.
        row = 1000;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h70; done = 4'h0;
        #1 chk("in_ready_empty_hold", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_data = 8'h71;
        #1 chk("in_ready_iv1", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #1 chk("in_ready_iv0", 32'(in_ready), 32'd0);
        done = 4'h2;
        @(negedge clk);
        done = 4'h0;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (out_valid != 4'h0) seen = 1'b1;
        end
        chk("dispatch_seen", 32'(seen), 32'd1);
        chk("late_out_valid", 32'(out_valid), 32'h2);
        chk("late_sel",       32'(sel),       32'd1);
        chk("late_out_data",  32'(out_data),  32'h70);
        @(posedge clk);
        #1 chk("strobe_one_cycle", 32'(out_valid), 32'h0);
        chk("busy_after_late", 32'(busy), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
